// File: rtl/if_types.sv
`default_nettype none
// ============================================================================
//  Module      : if_types
//  Description : Fetch-stage types. Holds the fetch state encoding and the
//                RV32I major opcode values.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package if_types;

    // Explicit one-bit encoding for the fetch engine states
    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared pipeline-boundary register types. Holds the IF/ID
//                word produced by the fetch unit and consumed by decode.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Field order is {valid, pc, instr, i_imm, b_imm, j_imm}, MSB first
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] i_imm;
        logic [31:0] b_imm;
        logic [31:0] j_imm;
    } if_id_regfile;

endpackage
`default_nettype wire

// File: rtl/if_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : if_imm_gen
//  Description : Combinational RV32I immediate extraction. Produces the
//                sign-extended I, B and J format immediates of one word.
//                Shared between fetch and decode-side checks.
//  Ports       : instr  in  32  instruction word
//                i_imm  out 32  I-type immediate
//                b_imm  out 32  B-type immediate (byte offset, bit 0 = 0)
//                j_imm  out 32  J-type immediate (byte offset, bit 0 = 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module if_imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] i_imm,
    output logic [31:0] b_imm,
    output logic [31:0] j_imm
);

    // The opcode field carries no immediate bits in any of the three formats
    logic [6:0] w_unused_opcode;
    assign w_unused_opcode = instr[6:0];

    assign i_imm = {{20{instr[31]}}, instr[31:20]};

    // B: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7]
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};

    // J: imm[20|10:1|11|19:12] in [31:12]
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : IF-stage fetch engine. Owns the PC, runs the single
//                outstanding instruction-memory read handshake, and fills
//                the IF/ID word (with immediates) for decode. Accepts
//                redirects from ID and EXE and discards stale responses.
//                A one-entry skid buffer sits behind reg_out so a response
//                that lands while ID is stalled is never lost.
//  Config      : IF_PERF_CNT_EN - adds perf_fetched / perf_dropped /
//                perf_stalled 32-bit wrapping counters.
//  Ports       : clk, rst (async, active-high)
//                stall                     ID bubbling, hold reg_out
//                id_redirect/id_target     ID jump/branch redirect
//                exe_redirect/exe_target   EXE mispredict redirect
//                imem_read/imem_address    memory read request
//                imem_rdata/imem_resp      memory response
//                reg_out                   IF/ID word
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_types::*;
    import regfile_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         id_redirect,
    input  logic [31:0]  id_target,
    input  logic         exe_redirect,
    input  logic [31:0]  exe_target,
    output logic         imem_read,
    output logic [31:0]  imem_address,
    input  logic [31:0]  imem_rdata,
    input  logic         imem_resp,
    output if_id_regfile reg_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_dropped,
    output logic [31:0]  perf_stalled
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend;      // redirect target waiting for the stale response
    logic         r_started;   // delays the first request to the cycle after reset
    if_id_regfile r_reg_out;
    if_id_regfile r_skid;      // r_skid.valid doubles as the skid-full flag

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic         w_redir;
    logic [31:0]  w_target;
    logic         w_read;
    logic         w_resp;
    logic         w_capture;
    logic         w_drop;
    logic         w_free;
    logic [31:0]  w_i_imm;
    logic [31:0]  w_b_imm;
    logic [31:0]  w_j_imm;
    if_id_regfile w_cap_word;

    // EXE wins over both ID and stall; ID is ignored while stalled
    assign w_redir  = exe_redirect | (id_redirect & ~stall);
    assign w_target = exe_redirect ? exe_target : id_target;

    // A new request is only issued when the skid has room for its result,
    // so the single in-flight word can always land somewhere. In DISCARD
    // the stale request must be held until its response arrives.
    assign w_read   = r_started & ((r_state == DISCARD) | ~r_skid.valid);

    // Responses with no request outstanding are ignored
    assign w_resp    = imem_resp & w_read;
    assign w_capture = w_resp & (r_state == FETCH) & ~w_redir;
    assign w_drop    = w_resp & ~w_capture;

    // reg_out can take a new word unless it holds a valid word ID is stalling on
    assign w_free    = ~r_reg_out.valid | ~stall;

    if_imm_gen u_imm_gen (
        .instr (imem_rdata),
        .i_imm (w_i_imm),
        .b_imm (w_b_imm),
        .j_imm (w_j_imm)
    );

    always_comb begin
        w_cap_word       = '0;
        w_cap_word.valid = 1'b1;
        w_cap_word.pc    = r_pc;
        w_cap_word.instr = imem_rdata;
        w_cap_word.i_imm = w_i_imm;
        w_cap_word.b_imm = w_b_imm;
        w_cap_word.j_imm = w_j_imm;
    end

    // ------------------------------------------------------------------
    // Fetch FSM, PC and capture path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC;
            r_pend    <= RESET_PC;
            r_started <= 1'b0;
            r_reg_out <= '0;
            r_skid    <= '0;
        end else begin
            r_started <= 1'b1;

            case (r_state)
                FETCH: begin
                    if (w_resp) begin
                        // Same-cycle redirect drops the word and retargets
                        r_pc <= w_redir ? w_target : (r_pc + 32'd4);
                    end else if (w_redir) begin
                        if (w_read) begin
                            // Request in flight: keep address stable, drop it later
                            r_pend  <= w_target;
                            r_state <= DISCARD;
                        end else begin
                            // Nothing outstanding, retarget immediately
                            r_pc <= w_target;
                        end
                    end
                end
                DISCARD: begin
                    if (w_resp) begin
                        r_pc    <= w_redir ? w_target : r_pend;
                        r_state <= FETCH;
                    end else if (w_redir) begin
                        r_pend <= w_target;
                    end
                end
                default: r_state <= FETCH;
            endcase

            if (w_redir) begin
                r_reg_out.valid <= 1'b0;
                r_skid.valid    <= 1'b0;
            end else if (w_free) begin
                if (r_skid.valid) begin
                    // Older skid word goes first to preserve program order
                    r_reg_out    <= r_skid;
                    r_skid.valid <= w_capture;
                    if (w_capture) begin
                        r_skid <= w_cap_word;
                    end
                end else if (w_capture) begin
                    r_reg_out <= w_cap_word;
                end else if (!stall) begin
                    r_reg_out.valid <= 1'b0;
                end
            end else if (w_capture) begin
                r_skid <= w_cap_word;
            end
        end
    end

    assign imem_read    = w_read;
    assign imem_address = r_pc;
    assign reg_out      = r_reg_out;

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_stalled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
            r_perf_stalled <= '0;
        end else begin
            if (w_capture) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_drop) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
            if (!w_read) begin
                r_perf_stalled <= r_perf_stalled + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign perf_stalled = r_perf_stalled;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Self-checking bench for if_fetch_unit. Directed scenarios
//                followed by randomized stalls, redirects and memory
//                latency, checked against an in-order delivery model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;
    import regfile_pkg::*;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0060;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         id_redirect = 1'b0;
    logic [31:0]  id_target = '0;
    logic         exe_redirect = 1'b0;
    logic [31:0]  exe_target = '0;
    logic         imem_read;
    logic [31:0]  imem_address;
    logic [31:0]  imem_rdata = '0;
    logic         imem_resp = 1'b0;
    if_id_regfile reg_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0]  perf_fetched;
    logic [31:0]  perf_dropped;
    logic [31:0]  perf_stalled;
`endif

    if_fetch_unit #(.RESET_PC(c_RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .id_redirect  (id_redirect),
        .id_target    (id_target),
        .exe_redirect (exe_redirect),
        .exe_target   (exe_target),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .reg_out      (reg_out)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped),
        .perf_stalled (perf_stalled)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_deliv = 0;
    int          idle = 0;
    int          lat = 0;
    bit          auto_mode = 1'b0;
    bit          force_resp = 1'b0;
    logic [31:0] e_pc = c_RESET_PC;   // next pc decode must see, in program order

    // Instruction memory contents as a pure function of address
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0400) return 32'hFE00_0EE3;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_i(input logic [31:0] w);
        return $signed(w) >>> 20;
    endfunction

    function automatic logic [31:0] ref_b(input logic [31:0] w);
        logic signed [12:0] b;
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        return 32'(b);
    endfunction

    function automatic logic [31:0] ref_j(input logic [31:0] w);
        logic signed [20:0] j;
        j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return 32'(j);
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 15) == 0)
            return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        return 32'($urandom_range(0, 1023) * 4);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the memory side, sample pre-edge state, advance,
    // then check the DUT against the delivery-order model.
    task automatic cyc();
        logic         resp_now;
        if_id_regfile p_ro;
        logic         p_read;
        logic [31:0]  p_addr;
        logic         p_stall;
        logic         p_exe;
        logic         p_redir;
        logic [31:0]  p_tgt;
        if (auto_mode) begin
            if (imem_read) begin
                if (lat == 0) begin
                    resp_now = 1'b1;
                    lat = $urandom_range(0, 3);
                end else begin
                    resp_now = 1'b0;
                    lat--;
                end
            end else begin
                resp_now = ($urandom_range(0, 7) == 0);   // spurious pulse
            end
        end else begin
            resp_now = force_resp;
        end
        imem_resp  = resp_now;
        imem_rdata = (resp_now && imem_read) ? mem(imem_address) : $urandom;
        p_ro    = reg_out;
        p_read  = imem_read;
        p_addr  = imem_address;
        p_stall = stall;
        p_exe   = exe_redirect;
        p_redir = exe_redirect || (id_redirect && !stall);
        p_tgt   = exe_redirect ? exe_target : id_target;
        @(posedge clk);
        #1;
        if (p_ro.valid && !p_stall) begin
            chk("deliver_pc", p_ro.pc, e_pc);
            chk("deliver_instr", p_ro.instr, mem(p_ro.pc));
            chk("deliver_i_imm", p_ro.i_imm, ref_i(p_ro.instr));
            chk("deliver_b_imm", p_ro.b_imm, ref_b(p_ro.instr));
            chk("deliver_j_imm", p_ro.j_imm, ref_j(p_ro.instr));
            e_pc = e_pc + 32'd4;
            n_deliv++;
            idle = 0;
        end else begin
            idle++;
        end
        if (p_redir) begin
            e_pc = p_tgt;
            chk("flush_valid", reg_out.valid, 1'b0);
        end
        if (p_ro.valid && p_stall && !p_exe)
            chk("stall_hold", reg_out, p_ro);
        if (p_read && !resp_now) begin
            chk("read_hold", imem_read, 1'b1);
            chk("addr_hold", imem_address, p_addr);
        end
        if (idle > 200) begin
            chk("progress_watchdog", 256'(idle), 256'(0));
            idle = 0;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit idr, input logic [31:0] idt,
                        input bit exr, input logic [31:0] ext);
        force_resp   = r;
        stall        = s;
        id_redirect  = idr;
        id_target    = idt;
        exe_redirect = exr;
        exe_target   = ext;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reg_out", reg_out, '0);
        chk("rst_read", imem_read, 1'b0);
        chk("rst_addr", imem_address, c_RESET_PC);
        rst = 1'b0;

        // ---------------- sequential fetch, resp every 2 cycles ----------------
        step(0, 0, 0, 0, 0, 0);
        chk("first_req_read", imem_read, 1'b1);
        chk("first_req_addr", imem_address, 32'h60);
        step(1, 0, 0, 0, 0, 0);
        chk("lat_valid", reg_out.valid, 1'b1);
        chk("lat_pc_60", reg_out.pc, 32'h60);
        chk("lat_instr_60", reg_out.instr, mem(32'h60));
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("pc_64", reg_out.pc, 32'h64);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("pc_68", reg_out.pc, 32'h68);

        // ---------------- ID redirect with request pending ----------------
        step(0, 0, 1, 32'h200, 0, 0);
        chk("pend_addr_hold", imem_address, 32'h6C);
        step(1, 0, 0, 0, 0, 0);
        chk("stale_dropped", reg_out.valid, 1'b0);
        chk("redir_addr_200", imem_address, 32'h200);

        // ---------------- redirect and response in the same cycle ----------------
        step(1, 0, 1, 32'h300, 0, 0);
        chk("same_cyc_valid", reg_out.valid, 1'b0);
        chk("same_cyc_addr", imem_address, 32'h300);
        step(1, 0, 0, 0, 0, 0);
        chk("pc_300", reg_out.pc, 32'h300);

        // ---------------- 5-cycle stall, word lands in skid ----------------
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("skid_full_read", imem_read, 1'b0);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        chk("stall_read_low", imem_read, 1'b0);
        chk("stall_pc_held", reg_out.pc, 32'h300);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_pc", reg_out.pc, 32'h304);
        chk("drain_valid", reg_out.valid, 1'b1);
        chk("drain_read", imem_read, 1'b1);
        chk("drain_addr", imem_address, 32'h308);

        // ---------------- EXE priority over stalled ID redirect ----------------
        step(1, 1, 0, 0, 0, 0);
        chk("skid_refill_read", imem_read, 1'b0);
        step(0, 1, 1, 32'h500, 1, 32'h400);
        chk("exe_flush_valid", reg_out.valid, 1'b0);
        chk("exe_addr_400", imem_address, 32'h400);
        chk("exe_read", imem_read, 1'b1);

        // ---------------- branch immediate ----------------
        step(1, 0, 0, 0, 0, 0);
        chk("beq_pc", reg_out.pc, 32'h400);
        chk("beq_instr", reg_out.instr, 32'hFE00_0EE3);
        chk("beq_b_imm", reg_out.b_imm, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);

`ifdef IF_PERF_CNT_EN
        chk("perf_fetched_run", perf_fetched, 32'd7);
        chk("perf_dropped_run", perf_dropped, 32'd2);
        chk("perf_stalled_run", perf_stalled, 32'd6);
`endif

        // ---------------- asynchronous reset mid-request ----------------
        #2;
        rst = 1'b1;
        #1;
        chk("arst_read", imem_read, 1'b0);
        chk("arst_reg_out", reg_out, '0);
        chk("arst_addr", imem_address, c_RESET_PC);
`ifdef IF_PERF_CNT_EN
        chk("arst_perf_fetched", perf_fetched, 32'd0);
        chk("arst_perf_dropped", perf_dropped, 32'd0);
        chk("arst_perf_stalled", perf_stalled, 32'd0);
`endif
        imem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        e_pc  = c_RESET_PC;
        lat   = 0;
        idle  = 0;

        // Response with no request outstanding must be ignored
        step(1, 0, 0, 0, 0, 0);
        chk("spurious_ignored", reg_out.valid, 1'b0);
        chk("post_rst_addr", imem_address, c_RESET_PC);

        // ---------------- randomized traffic ----------------
        auto_mode = 1'b1;
        n_deliv   = 0;
        for (int k = 0; k < 3000; k++) begin
            stall        = ($urandom_range(0, 3) == 0);
            id_redirect  = ($urandom_range(0, 15) == 0);
            exe_redirect = ($urandom_range(0, 31) == 0);
            id_target    = rand_target();
            exe_target   = rand_target();
            cyc();
        end
        chk("random_deliveries", 256'(n_deliv > 300), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
